// File: rtl/cpu_mem_bridge.sv
// CPU-side initiator for the memory controller's CPU read/write port.
// Optional request watchdog is enabled with `define MEM_TIMEOUT_EN.
module cpu_mem_bridge #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr,
  input  logic              mem_rd,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              stall,
  output logic              bus_err,
  output logic [DATA_W-1:0] cpu_rw_addr,
  output logic [1:0]        cpu_rw,
  inout  wire  [DATA_W-1:0] cpu_rw_data,
  input  logic              cpu_rw_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] wr_data;
  logic              is_write;
  logic              accept;
  logic              complete;
  logic              abort;
  logic              timeout_hit;

  // Only a registered write request ever enables the bus driver.
  assign cpu_rw_data = (cpu_rw == 2'b10) ? wr_data : {DATA_W{1'bz}};

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts BUSY cycles spent waiting for the responder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= {CNT_W{1'b0}};
    end else if (accept) begin
      tmo_cnt <= {CNT_W{1'b0}};
    end else if ((state == BUSY) && !cpu_rw_vld && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, pipeline stall and transaction events.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_rd | mem_wr;
        if (mem_rd | mem_wr) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        // A completion strobe in the expiry cycle takes priority over the abort.
        if (cpu_rw_vld) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = BUSY;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, bus request and load-data/error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rw_addr <= {DATA_W{1'b0}};
      wr_data     <= {DATA_W{1'b0}};
      is_write    <= 1'b0;
      cpu_rw      <= 2'b00;
      mem_rd_data <= {DATA_W{1'b0}};
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (accept) begin
        cpu_rw_addr <= mem_addr;
        wr_data     <= mem_wr_data;
        is_write    <= mem_wr;
        cpu_rw      <= {1'b1, ~mem_wr};
        bus_err     <= mem_rd & mem_wr;
      end else if (complete || abort) begin
        cpu_rw  <= 2'b00;
        bus_err <= abort;
        if (!is_write) begin
          mem_rd_data <= complete ? cpu_rw_data : DATA_W'(32'hDEADBEEF);
        end else begin
          mem_rd_data <= mem_rd_data;
        end
      end else begin
        cpu_rw <= cpu_rw;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: transaction-level reference plus literal spot checks.
module tb_cpu_mem_bridge;
  localparam int          W  = 32;
  localparam int          T  = 16;
  localparam logic [31:0] BG = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wr_data = 32'h0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] mem_rd_data;
  logic        stall;
  logic        bus_err;
  logic [31:0] cpu_rw_addr;
  logic [1:0]  cpu_rw;
  wire  [31:0] cpu_rw_data;
  logic        cpu_rw_vld = 1'b0;
  logic        tb_drv;
  logic [31:0] tb_val = BG;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: one outstanding request at a time.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_data = 32'h0;
  int          m_wait = 0;
  logic [31:0] m_rd_data = 32'h0;
  bit          m_err = 1'b0;

  // Responder side: drives the bus whenever the bridge is not expected to.
  assign tb_drv = !(m_busy && m_wr);
  assign cpu_rw_data = tb_drv ? tb_val : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  cpu_mem_bridge #(.DATA_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data), .stall(stall),
    .bus_err(bus_err), .cpu_rw_addr(cpu_rw_addr), .cpu_rw(cpu_rw),
    .cpu_rw_data(cpu_rw_data), .cpu_rw_vld(cpu_rw_vld)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_wait = 0;
      m_rd_data = 32'h0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_busy) begin
        if (cpu_rw_vld) begin
          if (!m_wr) m_rd_data = tb_val;
          m_busy = 1'b0; m_done = 1'b1;
`ifdef MEM_TIMEOUT_EN
        end else if (m_wait == T - 1) begin
          if (!m_wr) m_rd_data = 32'hDEAD_BEEF;
          m_err = 1'b1; m_busy = 1'b0; m_done = 1'b1;
`endif
        end else begin
          m_wait++;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (mem_rd || mem_wr) begin
        m_busy = 1'b1; m_wr = mem_wr; m_addr = mem_addr; m_data = mem_wr_data;
        m_wait = 0; m_err = mem_rd && mem_wr;
      end
    end
  end

  always @(negedge clk) begin
    chk("cpu_rw", {30'h0, cpu_rw}, m_busy ? {30'h0, 1'b1, ~m_wr} : 32'h0);
    chk("stall", {31'h0, stall}, {31'h0, m_busy || (!m_done && (mem_rd || mem_wr))});
    chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
    chk("mem_rd_data", mem_rd_data, m_rd_data);
    chk("bus", cpu_rw_data, (m_busy && m_wr) ? m_data : tb_val);
    if (m_busy) chk("cpu_rw_addr", cpu_rw_addr, m_addr);
  end

  // One access: IDLE cycle, nb BUSY cycles (vld on cycle va, 0 = never), DONE cycle.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input int nb, input int va, input logic [31:0] rv,
                     output int st_n, output int rq_n, output int er_n);
    st_n = 0; rq_n = 0; er_n = 0;
    mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wr_data = d;
    cpu_rw_vld = 1'b0; tb_val = BG;
    for (int i = 0; i <= nb + 1; i++) begin
      cpu_rw_vld = (i == va) && (va != 0);
      tb_val = ((i == va) && (va != 0) && !wr) ? rv : BG;
      #3;
      st_n += int'(stall); rq_n += int'(cpu_rw[1]); er_n += int'(bus_err);
      @(posedge clk); #1;
    end
    cpu_rw_vld = 1'b0; tb_val = BG;
  endtask

  task automatic idle(input int n);
    mem_rd = 1'b0; mem_wr = 1'b0; cpu_rw_vld = 1'b0; tb_val = BG;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int st, rq, er;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_cpu_rw", {30'h0, cpu_rw}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rd_data", mem_rd_data, 32'h0);
    chk("rst_bus", cpu_rw_data, BG);
    @(posedge clk); #1;

    // 1: store, vld on third BUSY cycle
    txn(1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_1234, 3, 3, 32'h0, st, rq, er);
    chk("store_stall_cycles", st, 4);
    chk("store_req_cycles", rq, 3);
    idle(1);
    chk("store_bus_released", cpu_rw_data, BG);

    // 2: load, vld on first BUSY cycle
    txn(1'b1, 1'b0, 32'h0000_2004, 32'h0, 1, 1, 32'hCAFE_F00D, st, rq, er);
    chk("load_stall_cycles", st, 2);
    chk("load_req_cycles", rq, 1);
    chk("load_data", mem_rd_data, 32'hCAFE_F00D);
    idle(2);

    // 3: back-to-back load then store, requests held through DONE
    txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 2, 2, 32'h1111_2222, st, rq, er);
    chk("b2b_load_req_cycles", rq, 2);
    txn(1'b0, 1'b1, 32'h0000_3004, 32'h3333_4444, 2, 2, 32'h0, st, rq, er);
    chk("b2b_store_req_cycles", rq, 2);
    chk("b2b_store_stall", st, 3);
    chk("b2b_rd_data_kept", mem_rd_data, 32'h1111_2222);
    idle(2);

    // 4: rd+wr together issues a write with an error pulse; stray vld in IDLE
    txn(1'b1, 1'b1, 32'h0000_4000, 32'h5555_6666, 1, 1, 32'h0, st, rq, er);
    chk("illegal_err_pulses", er, 1);
    chk("illegal_req_cycles", rq, 1);
    idle(1);
    cpu_rw_vld = 1'b1; tb_val = 32'hFFFF_0000;
    @(posedge clk); #1;
    cpu_rw_vld = 1'b0; tb_val = BG;
    #3;
    chk("stray_vld_cpu_rw", {30'h0, cpu_rw}, 32'h0);
    chk("stray_vld_rd_data", mem_rd_data, 32'h1111_2222);
    idle(2);

`ifdef MEM_TIMEOUT_EN
    // 5: watchdog abort, then vld exactly on the expiry cycle
    txn(1'b1, 1'b0, 32'h0000_5000, 32'h0, T, 0, 32'h0, st, rq, er);
    chk("tmo_err_pulses", er, 1);
    chk("tmo_req_cycles", rq, T);
    chk("tmo_rd_data", mem_rd_data, 32'hDEAD_BEEF);
    idle(2);
    txn(1'b1, 1'b0, 32'h0000_5004, 32'h0, T, T, 32'h7777_8888, st, rq, er);
    chk("tmo_race_err", er, 0);
    chk("tmo_race_rd_data", mem_rd_data, 32'h7777_8888);
    idle(2);
`endif

    // 6: asynchronous reset in the middle of a write
    mem_wr = 1'b1; mem_addr = 32'h0000_6000; mem_wr_data = 32'h9999_AAAA;
    repeat (2) begin @(posedge clk); #1; end
    #1;
    chk("pre_rst_bus_driven", cpu_rw_data, 32'h9999_AAAA);
    #1 rst_n = 1'b0; mem_wr = 1'b0;
    #1;
    chk("rst_mid_cpu_rw", {30'h0, cpu_rw}, 32'h0);
    chk("rst_mid_bus", cpu_rw_data, BG);
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'h0000_6004, 32'h0, 1, 1, 32'h0BAD_CAFE, st, rq, er);
    chk("post_rst_stall", st, 2);
    chk("post_rst_load", mem_rd_data, 32'h0BAD_CAFE);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
